// File: rtl/tm1638_seg_pkg.sv
// TM1638 segment scheduler: shared states, limits and shadow cell type.
// Imported by the scheduler top and its interval timer.
package tm1638_seg_pkg;

  localparam int MAX_DIGITS = 8;
  localparam int TIMER_W    = 16;

  typedef enum logic [1:0] {
    IDLE,
    WR_REQ,
    RD_REQ,
    SKIP
  } seg_state_e;

  typedef struct packed {
    logic [3:0] nib;
    logic       dp;
  } seg_cell_t;

endpackage

// File: rtl/tm1638_seg_sched_if.sv
// Request/ready handshake between the scheduler and a TM1638 controller.
// master = scheduler side, slave = controller side.
interface tm1638_seg_sched_if;

  logic       READY;
  logic       READ_BUTTON;
  logic       WRITE_SEG;
  logic [2:0] SEG_INDEX;
  logic [3:0] SEG_DATA;
  logic       SEG_DP;

  modport master (
    input  READY,
    output READ_BUTTON,
    output WRITE_SEG,
    output SEG_INDEX,
    output SEG_DATA,
    output SEG_DP
  );

  modport slave (
    output READY,
    input  READ_BUTTON,
    input  WRITE_SEG,
    input  SEG_INDEX,
    input  SEG_DATA,
    input  SEG_DP
  );

endinterface

// File: rtl/tm1638_seg_interval_timer.sv
// Down-counting interval timer: DUE holds once the period has elapsed
// until CLEAR restarts it.
module tm1638_seg_interval_timer
  import tm1638_seg_pkg::*;
#(
  parameter int PERIOD = 32
) (
  input  logic CLK_IN,
  input  logic RST_IN,
  input  logic ENABLE,
  input  logic CLEAR,
  output logic DUE
);

  localparam logic [TIMER_W-1:0] LOAD =
    TIMER_W'(PERIOD - 1);

  logic [TIMER_W-1:0] cnt;

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      cnt <= LOAD;
    end else if (CLEAR) begin
      cnt <= LOAD;
    end else if (ENABLE && cnt != '0) begin
      cnt <= cnt - TIMER_W'(1);
    end
  end

  assign DUE = (cnt == '0);

endmodule

// File: rtl/tm1638_seg_sched.sv
// TM1638 digit-write / button-read request scheduler.
// Define TM1638_SEG_SKIP_UNCHANGED_EN to skip writes of unchanged digits.
module tm1638_seg_sched
  import tm1638_seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 8,
  parameter int WRITE_PERIOD = 32,
  parameter int READ_PERIOD  = 1024
) (
  input  logic                    CLK_IN,
  input  logic                    RST_IN,
  tm1638_seg_sched_if.master      ctl,
  input  logic [4*NUM_DIGITS-1:0] SEG_HEX_ALL,
  input  logic [NUM_DIGITS-1:0]   DP_ALL,
  input  logic                    FORCE_REFRESH,
  output logic                    FRAME_DONE
);

  localparam logic [2:0] IDX_LAST =
    3'(NUM_DIGITS - 1);

  seg_state_e state;
  logic       rd_btn;
  logic       wr_seg;
  logic       done;
  logic [2:0] idx;
  logic [2:0] idx_nxt;
  logic       wrap;
  logic [3:0] nib;
  logic       dp;
  logic       tmr_en;
  logic       wr_clr;
  logic       rd_clr;
  logic       wr_due;
  logic       rd_due;
  logic       skip_hit;

  always_comb begin
    nib = '0;
    dp  = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == 3'(i)) begin
        nib = SEG_HEX_ALL[4*(NUM_DIGITS-1-i) +: 4];
        dp  = DP_ALL[NUM_DIGITS-1-i];
      end
    end
  end

  assign wrap    = (idx == IDX_LAST);
  assign idx_nxt = wrap ? 3'd0 : idx + 3'd1;

  assign tmr_en = (state == IDLE) && ctl.READY;
  assign wr_clr = (state == WR_REQ) && !ctl.READY;
  assign rd_clr = (state == RD_REQ) && !ctl.READY;

  tm1638_seg_interval_timer #(
    .PERIOD(WRITE_PERIOD)
  ) u_wr_tmr (
    .CLK_IN (CLK_IN),
    .RST_IN (RST_IN),
    .ENABLE (tmr_en),
    .CLEAR  (wr_clr),
    .DUE    (wr_due)
  );

  tm1638_seg_interval_timer #(
    .PERIOD(READ_PERIOD)
  ) u_rd_tmr (
    .CLK_IN (CLK_IN),
    .RST_IN (RST_IN),
    .ENABLE (tmr_en),
    .CLEAR  (rd_clr),
    .DUE    (rd_due)
  );

`ifdef TM1638_SEG_SKIP_UNCHANGED_EN
  seg_cell_t              shadow [MAX_DIGITS];
  logic [MAX_DIGITS-1:0]  shadow_vld;

  // A refresh on the accept edge wins over the new shadow entry.
  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      shadow_vld <= '0;
    end else if (FORCE_REFRESH) begin
      shadow_vld <= '0;
    end else if (wr_clr) begin
      shadow_vld[idx] <= 1'b1;
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (wr_clr) begin
      shadow[idx] <= seg_cell_t'({nib, dp});
    end
  end

  assign skip_hit = shadow_vld[idx] &&
    (shadow[idx] == seg_cell_t'({nib, dp}));
`else
  logic unused_force;

  assign unused_force = FORCE_REFRESH;
  assign skip_hit     = 1'b0;
`endif

  always_ff @(posedge CLK_IN or posedge RST_IN) begin
    if (RST_IN) begin
      state  <= IDLE;
      rd_btn <= 1'b0;
      wr_seg <= 1'b0;
      idx    <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ctl.READY) begin
            if (rd_due) begin
              state  <= RD_REQ;
              rd_btn <= 1'b1;
            end else if (wr_due && skip_hit) begin
              state <= SKIP;
            end else if (wr_due) begin
              state  <= WR_REQ;
              wr_seg <= 1'b1;
            end
          end
        end
        RD_REQ: begin
          if (!ctl.READY) begin
            state  <= IDLE;
            rd_btn <= 1'b0;
          end
        end
        WR_REQ: begin
          if (!ctl.READY) begin
            state  <= IDLE;
            wr_seg <= 1'b0;
            idx    <= idx_nxt;
            done   <= wrap;
          end
        end
        SKIP: begin
          state <= IDLE;
          idx   <= idx_nxt;
          done  <= wrap;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ctl.READ_BUTTON = rd_btn;
  assign ctl.WRITE_SEG   = wr_seg;
  assign ctl.SEG_INDEX   = idx;
  assign ctl.SEG_DATA    = nib;
  assign ctl.SEG_DP      = dp;
  assign FRAME_DONE      = done;

endmodule

// File: tb/tb_tm1638_seg_sched.sv
// Scoreboard bench for tm1638_seg_sched: 4-digit display, write period 8,
// plus a second instance with equal read/write periods.
module tb_tm1638_seg_sched;

  localparam int ND = 4;
  localparam int WP = 8;

  typedef struct packed {
    logic [2:0] i;
    logic [3:0] d;
    logic       p;
  } exp_t;

  logic        CLK_IN = 1'b0;
  logic        RST_IN = 1'b1;
  logic [15:0] hex    = 16'hA5C3;
  logic [3:0]  dp     = 4'b0100;
  logic        force_r = 1'b0;
  logic        fd_a;
  logic        fd_b;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q[$];
  int   exp_frame_wr = 4;
  int   wr_in_frame = 0;
  int   idle_hi = 0;
  bit   track = 1'b1;
  bit   gap_chk = 1'b1;
  bit   hold = 1'b0;
  bit   pw, pr, pwb, prb;
  int   nreq_b = 0;
  int   nrd_b = 0;
  int   nwr_b = 0;

  always #5 CLK_IN = ~CLK_IN;

  tm1638_seg_sched_if bus_a ();
  tm1638_seg_sched_if bus_b ();

  tm1638_seg_sched #(
    .NUM_DIGITS(ND), .WRITE_PERIOD(WP), .READ_PERIOD(1000)
  ) dut_a (
    .CLK_IN(CLK_IN), .RST_IN(RST_IN), .ctl(bus_a),
    .SEG_HEX_ALL(hex), .DP_ALL(dp),
    .FORCE_REFRESH(force_r), .FRAME_DONE(fd_a)
  );

  tm1638_seg_sched #(
    .NUM_DIGITS(ND), .WRITE_PERIOD(8), .READ_PERIOD(8)
  ) dut_b (
    .CLK_IN(CLK_IN), .RST_IN(RST_IN), .ctl(bus_b),
    .SEG_HEX_ALL(hex), .DP_ALL(dp),
    .FORCE_REFRESH(force_r), .FRAME_DONE(fd_b)
  );

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input int i, input int d, input int p);
    q.push_back(exp_t'{3'(i), 4'(d), 1'(p)});
  endtask

  task automatic wait_fd(input int lim, input string nm);
    int ok;
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge CLK_IN);
      if (fd_a) begin
        ok = 1;
        break;
      end
    end
    chk({nm, "_frame_done_seen"}, ok, 1);
    #1;
  endtask

  always @(posedge CLK_IN) begin
    if (RST_IN) cyc <= 0;
    else cyc <= cyc + 1;
  end

  // Controller models: accept each request after two READY-high cycles.
  initial begin : resp_a
    int n;
    n = 0;
    bus_a.READY = 1'b1;
    forever begin
      @(posedge CLK_IN);
      #1;
      if (RST_IN) begin
        bus_a.READY = 1'b1;
        n = 0;
      end else if (hold) begin
        bus_a.READY = 1'b0;
      end else if (!bus_a.READY) begin
        bus_a.READY = 1'b1;
      end else if (bus_a.WRITE_SEG || bus_a.READ_BUTTON) begin
        n++;
        if (n == 2) begin
          bus_a.READY = 1'b0;
          n = 0;
        end
      end
    end
  end

  initial begin : resp_b
    int n;
    n = 0;
    bus_b.READY = 1'b1;
    forever begin
      @(posedge CLK_IN);
      #1;
      if (RST_IN) begin
        bus_b.READY = 1'b1;
        n = 0;
      end else if (!bus_b.READY) begin
        bus_b.READY = 1'b1;
      end else if (bus_b.WRITE_SEG || bus_b.READ_BUTTON) begin
        n++;
        if (n == 2) begin
          bus_b.READY = 1'b0;
          n = 0;
        end
      end
    end
  end

  always @(negedge CLK_IN) begin : mon_a
    exp_t e;
    if (RST_IN) begin
      idle_hi = 0;
      pw = 1'b0;
      pr = 1'b0;
    end else begin
      if ((bus_a.WRITE_SEG && !pw) || (bus_a.READ_BUTTON && !pr))
        chk("excl_a", int'(bus_a.WRITE_SEG && bus_a.READ_BUTTON), 0);
      if (bus_a.WRITE_SEG && !pw) begin
        if (gap_chk) chk("wr_gap_ready_cycles", idle_hi, WP);
        idle_hi = 0;
        if (track) begin
          wr_in_frame++;
          if (q.size() == 0) begin
            chk("sb_unexpected_write", 1, 0);
          end else begin
            e = q.pop_front();
            chk("wr_index", int'(bus_a.SEG_INDEX), int'(e.i));
            chk("wr_data", int'(bus_a.SEG_DATA), int'(e.d));
            chk("wr_dp", int'(bus_a.SEG_DP), int'(e.p));
          end
        end
      end else if (!bus_a.WRITE_SEG && !bus_a.READ_BUTTON && bus_a.READY) begin
        idle_hi++;
      end
      if (fd_a && track) begin
        chk("frame_write_count", wr_in_frame, exp_frame_wr);
        chk("wrap_index", int'(bus_a.SEG_INDEX), 0);
        wr_in_frame = 0;
      end
      pw = bus_a.WRITE_SEG;
      pr = bus_a.READ_BUTTON;
    end
  end

  always @(negedge CLK_IN) begin : mon_b
    if (RST_IN) begin
      pwb = 1'b0;
      prb = 1'b0;
    end else begin
      if ((bus_b.READ_BUTTON && !prb) || (bus_b.WRITE_SEG && !pwb)) begin
        chk("excl_b", int'(bus_b.READ_BUTTON && bus_b.WRITE_SEG), 0);
        if (nreq_b == 0) begin
          chk("b_first_is_read", int'(bus_b.READ_BUTTON), 1);
          chk("b_first_cycle", cyc, 8);
        end
        if (bus_b.WRITE_SEG && nwr_b == 0)
          chk("b_read_before_write", int'(nrd_b > 0), 1);
        if (bus_b.READ_BUTTON) nrd_b++;
        if (bus_b.WRITE_SEG) nwr_b++;
        nreq_b++;
      end
      pwb = bus_b.WRITE_SEG;
      prb = bus_b.READ_BUTTON;
    end
  end

  initial begin : stim
    int hold_req;
    int ok;
    repeat (3) @(posedge CLK_IN);
    @(negedge CLK_IN);
    chk("rst_write_seg", int'(bus_a.WRITE_SEG), 0);
    chk("rst_read_button", int'(bus_a.READ_BUTTON), 0);
    chk("rst_seg_index", int'(bus_a.SEG_INDEX), 0);
    chk("rst_frame_done", int'(fd_a), 0);
    chk("rst_seg_data", int'(bus_a.SEG_DATA), 'hA);
    @(posedge CLK_IN);
    #2 RST_IN = 1'b0;

    push(0, 'hA, 0);
    push(1, 'h5, 1);
    push(2, 'hC, 0);
    push(3, 'h3, 0);
    exp_frame_wr = 4;
    wait_fd(200, "frame1");

    hex = 16'h1234;
    dp = 4'b0000;
    push(0, 1, 0);
    push(1, 2, 0);
    push(2, 3, 0);
    push(3, 4, 0);
    hold = 1'b1;
    hold_req = 0;
    repeat (100) begin
      @(negedge CLK_IN);
      if (bus_a.WRITE_SEG || bus_a.READ_BUTTON) hold_req++;
    end
    chk("hold_no_request", hold_req, 0);
    hold = 1'b0;
    wait_fd(300, "frame2");

`ifdef TM1638_SEG_SKIP_UNCHANGED_EN
    gap_chk = 1'b0;
    exp_frame_wr = 0;
    wait_fd(200, "skip_frame");
    push(1, 2, 0);
    push(2, 3, 0);
    push(3, 4, 0);
    push(0, 1, 0);
    exp_frame_wr = 3;
    @(negedge CLK_IN);
    force_r = 1'b1;
    @(negedge CLK_IN);
    force_r = 1'b0;
    wait_fd(200, "force_frame_a");
    exp_frame_wr = 1;
    wait_fd(200, "force_frame_b");
`endif

    track = 1'b0;
    gap_chk = 1'b0;
    chk("sb_empty", q.size(), 0);
    chk("b_writes_seen", int'(nwr_b > 0), 1);

    hex = 16'h5678;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK_IN);
      if (bus_a.WRITE_SEG && bus_a.SEG_INDEX != 3'd0) begin
        ok = 1;
        break;
      end
    end
    chk("mid_write_seen", ok, 1);
    chk("mid_ready_high", int'(bus_a.READY), 1);
    #1 RST_IN = 1'b1;
    #1;
    chk("mid_rst_write_seg", int'(bus_a.WRITE_SEG), 0);
    chk("mid_rst_seg_index", int'(bus_a.SEG_INDEX), 0);
    chk("mid_rst_read_button", int'(bus_a.READ_BUTTON), 0);
    chk("mid_rst_frame_done", int'(fd_a), 0);
    repeat (3) @(posedge CLK_IN);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
